// File: rtl/jts16_hshift.sv
// jts16_hshift
// ------------
// Horizontal screen-centering stage for the S16 video output. The 5-bit RGB
// stream is written into a 32-entry circular buffer and read back with a
// programmable delay, which moves the picture left or right on screen.
// Blanking and sync pass through a fixed (DLY+1)-stage delay line, so their
// timing never depends on the shift. The shift value is only latched on the
// rising edge of VS_in, so every pixel of a frame sees the same delay.
//
// Build option:
//   JTS16_HSHIFT_EN  defined   : programmable shift, latched on the VS_in rise.
//                    undefined : shift input ignored, shift_l reads 0, and the
//                                block is a fixed DLY+1 pixel delay.
//
// Parameters:
//   DLY  fixed sync/blank delay in pixels (picture delay is DLY + shift)
//   AW   buffer address width, depth 2**AW (must be >= 2*DLY)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pxl_cen                   pixel clock enable, all state advances on it
//   shift[4:0]                signed shift -16..+15, positive moves right
//   red_in/green_in/blue_in   colour from the colour mixer
//   LHBL_in, LVBL_in          active-low blanking, aligned with RGB
//   HS_in, VS_in              sync, aligned with RGB
//   red/green/blue            shifted colour
//   LHBL, LVBL, HS, VS        blanking/sync delayed by DLY+1 pixels
//   shift_l[4:0]              shift currently in effect

module jts16_hshift #(
  parameter int DLY = 16,
  parameter int AW  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic [4:0] shift,
  input  logic [4:0] red_in,
  input  logic [4:0] green_in,
  input  logic [4:0] blue_in,
  input  logic       LHBL_in,
  input  logic       LVBL_in,
  input  logic       HS_in,
  input  logic       VS_in,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS,
  output logic [4:0] shift_l
);

  localparam int DEPTH = 1 << AW;
  localparam int NST   = DLY + 1;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic [14:0]   pix_w;
  logic [14:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   fill_q, fill_d;

  // Blanked pixels are stored as black. This is what makes the vacated edge
  // of a shifted line come out black instead of showing stale picture data.
  assign pix_w = (LHBL_in & LVBL_in) ? {red_in, green_in, blue_in} : 15'd0;

  always_comb begin
    wr_d   = wr_q + AW'(1);
    fill_d = (fill_q == (AW+1)'(DEPTH)) ? fill_q : fill_q + (AW+1)'(1);
  end

  // Buffer contents carry no reset: the fill counter masks them until every
  // slot has been written once.
  always_ff @(posedge clk) begin
    if (!rst && pxl_cen) begin
      mem_q[wr_q] <= pix_w;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift latch and picture delay
  // ---------------------------------------------------------------------------
  logic [4:0]    shift_l_w;
  logic [AW-1:0] dly_w;

`ifdef JTS16_HSHIFT_EN
  logic [4:0] shift_l_q, shift_l_d;
  logic       vs_q;

  // Only the rising edge of VS_in (inside vertical blanking) loads a new
  // shift. The write/read on that same cen still uses the old value.
  always_comb begin
    shift_l_d = shift_l_q;
    if (VS_in && !vs_q) begin
      shift_l_d = shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_l_q <= 5'd0;
      vs_q      <= 1'b0;
    end else if (pxl_cen) begin
      shift_l_q <= shift_l_d;
      vs_q      <= VS_in;
    end
  end

  assign shift_l_w = shift_l_q;

  // D = DLY + signed shift. With DLY = 16 this spans 0..31, so it always
  // fits in the buffer and never wraps picture content around.
  assign dly_w = AW'(DLY + int'($signed(shift_l_q)));
`else
  logic unused_shift;

  assign unused_shift = ^shift;
  assign shift_l_w    = 5'd0;
  assign dly_w        = AW'(DLY);
`endif

  assign shift_l = shift_l_w;

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  logic [AW-1:0] rd_addr;
  logic [14:0]   col_q, col_d;

  // Read address uses the pre-increment write pointer, so a delay of D
  // returns the pixel written D cens ago.
  assign rd_addr = wr_q - dly_w;

  always_comb begin
    col_d = 15'd0;
    if (fill_q < (AW+1)'(DEPTH)) begin
      col_d = 15'd0;
    end else if (dly_w == '0) begin
      // Zero delay targets the slot being written right now: bypass it.
      col_d = pix_w;
    end else begin
      col_d = mem_q[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Sync / blank delay line: {LHBL, LVBL, HS, VS}
  // ---------------------------------------------------------------------------
  logic [3:0] sync_q [NST];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      fill_q <= '0;
      col_q  <= 15'd0;
      for (int i = 0; i < NST; i++) begin
        sync_q[i] <= 4'd0;
      end
    end else if (pxl_cen) begin
      wr_q      <= wr_d;
      fill_q    <= fill_d;
      col_q     <= col_d;
      sync_q[0] <= {LHBL_in, LVBL_in, HS_in, VS_in};
      for (int i = 1; i < NST; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign red   = col_q[14:10];
  assign green = col_q[9:5];
  assign blue  = col_q[4:0];
  assign {LHBL, LVBL, HS, VS} = sync_q[NST-1];

endmodule

// File: tb/tb_jts16_hshift.sv
// Testbench for jts16_hshift. Every pixel cen is followed by one idle clock
// with pxl_cen low. Outputs are logged #1 after each cen edge; an input given
// on cen n and seen in the log entry of cen n+L-1 has a latency of L cens.

module tb_jts16_hshift;

  localparam int LOGN = 1024;
  localparam logic [14:0] MARK  = 15'h1400;  // red = 5
  localparam logic [14:0] MAGNT = 15'h7C1F;  // 1F/00/1F
  localparam logic [14:0] WHITE = 15'h7FFF;

`ifdef JTS16_HSHIFT_EN
  localparam int SH_EFF = 8;   // edge test: effective shift of +8
`else
  localparam int SH_EFF = 0;   // shift input ignored
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pxl_cen = 1'b0;
  logic [4:0] shift   = 5'd0;
  logic [4:0] red_in = 5'd0, green_in = 5'd0, blue_in = 5'd0;
  logic       LHBL_in = 1'b0, LVBL_in = 1'b0, HS_in = 1'b0, VS_in = 1'b0;
  logic [4:0] red, green, blue, shift_l;
  logic       LHBL, LVBL, HS, VS;

  jts16_hshift dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .shift    (shift),
    .red_in   (red_in),
    .green_in (green_in),
    .blue_in  (blue_in),
    .LHBL_in  (LHBL_in),
    .LVBL_in  (LVBL_in),
    .HS_in    (HS_in),
    .VS_in    (VS_in),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .HS       (HS),
    .VS       (VS),
    .shift_l  (shift_l)
  );

  // ---------------------------------------------------------------------------
  // Output log and scoreboard
  // ---------------------------------------------------------------------------
  logic [14:0] l_rgb  [LOGN];
  logic [3:0]  l_sync [LOGN];   // {LHBL, LVBL, HS, VS}
  logic [4:0]  l_shl  [LOGN];
  int          cen_n  = 0;
  int          n_cmp  = 0;
  int          n_bad  = 0;
  logic [14:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cen(input logic [14:0] rgb, input logic lh, input logic lv,
                     input logic hs, input logic vs);
    {red_in, green_in, blue_in} = rgb;
    LHBL_in = lh;
    LVBL_in = lv;
    HS_in   = hs;
    VS_in   = vs;
    pxl_cen = 1'b1;
    @(posedge clk);
    #1;
    if (cen_n < LOGN) begin
      l_rgb[cen_n]  = {red, green, blue};
      l_sync[cen_n] = {LHBL, LVBL, HS, VS};
      l_shl[cen_n]  = shift_l;
    end
    cen_n++;
    pxl_cen = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Vertical-blank cens with one VS_in rising edge.
  task automatic latch(input logic [4:0] s);
    shift = s;
    cen(15'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cen(15'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cen(15'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // 30 active black cens with a marker at cen 20, then 40 blank cens with an
  // HS pulse at blank cen 5. Returns measured latencies (-1 if not seen).
  task automatic marker_line(output int cd, output int bd, output int hd);
    int n0, mk, fl, hp;
    n0 = cen_n;
    for (int i = 0; i < 30; i++) cen((i == 20) ? MARK : 15'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cen(15'd0, 1'b0, 1'b1, (i == 5), 1'b0);
    mk = n0 + 20;
    fl = n0 + 30;
    hp = n0 + 35;
    cd = -1;
    bd = -1;
    hd = -1;
    for (int j = mk; j < mk + 40; j++) if (cd < 0 && l_rgb[j] == MARK) cd = j - mk + 1;
    for (int j = fl; j < fl + 39; j++) if (bd < 0 && l_sync[j][3] == 1'b0) bd = j - fl + 1;
    for (int j = hp; j < hp + 34; j++) if (hd < 0 && l_sync[j][1] == 1'b1) hd = j - hp + 1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [4:0] sh;
    bit         do_latch;
    int         exp_col;
    int         exp_blk;
    logic [4:0] exp_shl;
  } vec_t;

  vec_t vecs [6];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int r0, s, cd, bd, hd, got;

`ifdef JTS16_HSHIFT_EN
    vecs[0] = '{"zero",        5'd0,  1'b1, 17, 17, 5'd0};
    vecs[1] = '{"mid_frame",   5'd4,  1'b0, 17, 17, 5'd0};
    vecs[2] = '{"next_frame",  5'd4,  1'b1, 21, 17, 5'd4};
    vecs[3] = '{"pos15",       5'd15, 1'b1, 32, 17, 5'd15};
    vecs[4] = '{"neg16",       5'h10, 1'b1, 1,  17, 5'h10};
    vecs[5] = '{"shift7",      5'd7,  1'b1, 24, 17, 5'd7};
`else
    vecs[0] = '{"zero",        5'd0,  1'b1, 17, 17, 5'd0};
    vecs[1] = '{"mid_frame",   5'd4,  1'b0, 17, 17, 5'd0};
    vecs[2] = '{"next_frame",  5'd4,  1'b1, 17, 17, 5'd0};
    vecs[3] = '{"pos15",       5'd15, 1'b1, 17, 17, 5'd0};
    vecs[4] = '{"neg16",       5'h10, 1'b1, 17, 17, 5'd0};
    vecs[5] = '{"shift7",      5'd7,  1'b1, 17, 17, 5'd0};
`endif

    // Reset held for 4 cens with live inputs: everything must read 0.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cen(MAGNT, 1'b1, 1'b1, 1'b1, 1'b0);
      check($sformatf("reset_outputs_%0d", i), int'({l_rgb[cen_n-1], l_sync[cen_n-1], l_shl[cen_n-1]}), 0);
    end

    // Release and fill with a constant colour.
    rst = 1'b0;
    r0  = cen_n;
    for (int i = 0; i < 40; i++) cen(MAGNT, 1'b1, 1'b1, 1'b0, 1'b0);
    got = 0;
    for (int j = r0; j < r0 + 32; j++) if (l_rgb[j] != 15'd0) got++;
    check("fill_black_32", got, 0);
    check("fill_first_colour", int'(l_rgb[r0+32]), int'(MAGNT));
    check("fill_lhbl_before_17", int'(l_sync[r0+15][3]), 0);
    check("fill_lhbl_at_17", int'(l_sync[r0+16][3]), 1);

    // Table: marker and blanking latency for each shift setting.
    foreach (vecs[k]) begin
      if (vecs[k].do_latch) latch(vecs[k].sh);
      else shift = vecs[k].sh;
      marker_line(cd, bd, hd);
      check({vecs[k].name, "_colour_latency"}, cd, vecs[k].exp_col);
      check({vecs[k].name, "_lhbl_latency"}, bd, vecs[k].exp_blk);
      check({vecs[k].name, "_hs_latency"}, hd, 17);
      check({vecs[k].name, "_shift_l"}, int'(l_shl[cen_n-1]), int'(vecs[k].exp_shl));
    end

    // Edge blanking: +8 shift, 40 white active pixels then blanking.
    latch(5'd8);
    s = cen_n;
    for (int i = 0; i < 40; i++) cen(WHITE, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cen(15'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("edge_lhbl_rise", int'(l_sync[s+16][3]), 1);
    check("edge_lhbl_fall", int'(l_sync[s+56][3]), 0);
    for (int i = 0; i < 40; i++) exp_q.push_back((i < SH_EFF) ? 15'd0 : WHITE);
    for (int j = s + 16; j < s + 56; j++) begin
      check($sformatf("edge_pixel_%0d", j - s - 16), int'(l_rgb[j]), int'(exp_q.pop_front()));
    end

    // Reset in the middle of an active line.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cen(WHITE, 1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("midreset_outputs_%0d", i), int'({l_rgb[cen_n-1], l_sync[cen_n-1], l_shl[cen_n-1]}), 0);
    end
    rst = 1'b0;
    r0  = cen_n;
    for (int i = 0; i < 40; i++) cen(WHITE, 1'b1, 1'b1, 1'b0, 1'b0);
    got = 0;
    for (int j = r0; j < r0 + 32; j++) if (l_rgb[j] != 15'd0) got++;
    check("midreset_black_32", got, 0);
    check("midreset_first_colour", int'(l_rgb[r0+32]), int'(WHITE));
    check("midreset_lhbl_before_17", int'(l_sync[r0+15][3]), 0);
    check("midreset_lhbl_at_17", int'(l_sync[r0+16][3]), 1);
    check("midreset_shift_l", int'(l_shl[r0+39]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
